// File: rtl/joybus_cmd_sched.sv
// joybus_cmd_sched: arbitrates periodic polls and host commands onto one JOYBUS tx/rx engine pair.
module joybus_cmd_sched #(
   parameter int POLL_CYCLES        = 500000,
   parameter int RSP_TIMEOUT_CYCLES = 2500,
   parameter int MAX_RETRY          = 2,
   parameter int GAP_CYCLES         = 50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        poll_en,
   input  logic        req_valid,
   input  logic [7:0]  req_cmd,
   output logic        req_ready,
   output logic        cmd_rdy,
   output logic [7:0]  cmd_data,
   input  logic        tx_done,
   input  logic        rx_done,
   input  logic [31:0] rx_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_cmd,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] cntlr_data,
   output logic        cntlr_data_rdy,
   output logic        cntlr_present,
   output logic        busy
);
   localparam int PW = $clog2(POLL_CYCLES + 1);
   localparam int TW = $clog2(RSP_TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int AW = $clog2(MAX_RETRY + 2);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_TX, WAIT_RX, GAP} state_t;
   state_t        state_q, state_d;
   logic [PW-1:0] poll_cnt_q, poll_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [AW-1:0] attempt_q, attempt_d;
   logic          poll_pending_q, poll_pending_d;
   logic          last_host_q, last_host_d;
   logic          host_q, host_d;
   logic          retry_q, retry_d;
   logic [7:0]    cmd_q, cmd_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [7:0]    rsp_cmd_q, rsp_cmd_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic          rsp_err_q, rsp_err_d;
   logic [31:0]   cntlr_data_q, cntlr_data_d;
   logic          cntlr_data_rdy_q, cntlr_data_rdy_d;
   logic          cntlr_present_q, cntlr_present_d;
   logic          poll_wrap, grant_host, grant_poll;
   always_comb begin
      poll_wrap        = poll_en && poll_cnt_q == PW'(POLL_CYCLES - 1);
      grant_host       = state_q == IDLE && req_valid && (!poll_pending_q || !last_host_q);
      grant_poll       = state_q == IDLE && poll_pending_q && (!req_valid || last_host_q);
      poll_cnt_d       = (!poll_en || poll_wrap) ? '0 : poll_cnt_q + 1'b1;
      poll_pending_d   = poll_en && ((poll_pending_q && !grant_poll) || poll_wrap);
      state_d          = state_q;
      to_cnt_d         = to_cnt_q;
      gap_cnt_d        = gap_cnt_q;
      attempt_d        = attempt_q;
      last_host_d      = last_host_q;
      host_d           = host_q;
      retry_d          = retry_q;
      cmd_d            = cmd_q;
      rsp_valid_d      = 1'b0;
      rsp_cmd_d        = rsp_cmd_q;
      rsp_data_d       = rsp_data_q;
      rsp_err_d        = rsp_err_q;
      cntlr_data_d     = cntlr_data_q;
      cntlr_data_rdy_d = 1'b0;
      cntlr_present_d  = cntlr_present_q;
      case (state_q)
         IDLE: if (grant_host || grant_poll) begin
            cmd_d       = grant_host ? req_cmd : 8'h01;
            host_d      = grant_host;
            last_host_d = grant_host;
            attempt_d   = '0;
            state_d     = ISSUE;
         end
         ISSUE: state_d = WAIT_TX;
         WAIT_TX: if (tx_done) begin
            state_d  = WAIT_RX;
            to_cnt_d = '0;
         end
         WAIT_RX: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (rx_done || to_cnt_q == TW'(RSP_TIMEOUT_CYCLES - 1)) begin
               state_d   = GAP;
               gap_cnt_d = '0;
               retry_d   = 1'b0;
               // a response landing on the expiry cycle still wins over the timeout
               if (rx_done) begin
                  cntlr_present_d  = 1'b1;
                  rsp_valid_d      = host_q;
                  rsp_cmd_d        = host_q ? cmd_q : rsp_cmd_q;
                  rsp_data_d       = host_q ? rx_data : rsp_data_q;
                  rsp_err_d        = host_q ? 1'b0 : rsp_err_q;
                  cntlr_data_d     = host_q ? cntlr_data_q : rx_data;
                  cntlr_data_rdy_d = !host_q;
               end else if (attempt_q != AW'(MAX_RETRY)) begin
                  attempt_d = attempt_q + 1'b1;
                  retry_d   = 1'b1;
               end else begin
                  cntlr_present_d = 1'b0;
                  rsp_valid_d     = host_q;
                  rsp_cmd_d       = host_q ? cmd_q : rsp_cmd_q;
                  rsp_data_d      = host_q ? 32'h0 : rsp_data_q;
                  rsp_err_d       = host_q ? 1'b1 : rsp_err_q;
                  cntlr_data_d    = host_q ? cntlr_data_q : 32'h0;
               end
            end
         end
         GAP: begin
            gap_cnt_d = gap_cnt_q + 1'b1;
            if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = retry_q ? ISSUE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         poll_cnt_q       <= '0;
         to_cnt_q         <= '0;
         gap_cnt_q        <= '0;
         attempt_q        <= '0;
         poll_pending_q   <= 1'b0;
         last_host_q      <= 1'b0;
         host_q           <= 1'b0;
         retry_q          <= 1'b0;
         cmd_q            <= '0;
         rsp_valid_q      <= 1'b0;
         rsp_cmd_q        <= '0;
         rsp_data_q       <= '0;
         rsp_err_q        <= 1'b0;
         cntlr_data_q     <= '0;
         cntlr_data_rdy_q <= 1'b0;
         cntlr_present_q  <= 1'b0;
      end else begin
         state_q          <= state_d;
         poll_cnt_q       <= poll_cnt_d;
         to_cnt_q         <= to_cnt_d;
         gap_cnt_q        <= gap_cnt_d;
         attempt_q        <= attempt_d;
         poll_pending_q   <= poll_pending_d;
         last_host_q      <= last_host_d;
         host_q           <= host_d;
         retry_q          <= retry_d;
         cmd_q            <= cmd_d;
         rsp_valid_q      <= rsp_valid_d;
         rsp_cmd_q        <= rsp_cmd_d;
         rsp_data_q       <= rsp_data_d;
         rsp_err_q        <= rsp_err_d;
         cntlr_data_q     <= cntlr_data_d;
         cntlr_data_rdy_q <= cntlr_data_rdy_d;
         cntlr_present_q  <= cntlr_present_d;
      end
   end
   assign req_ready      = grant_host && rst_n;
   assign cmd_rdy        = state_q == ISSUE;
   assign cmd_data       = cmd_q;
   assign busy           = state_q != IDLE;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_cmd        = rsp_cmd_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_err        = rsp_err_q;
   assign cntlr_data     = cntlr_data_q;
   assign cntlr_data_rdy = cntlr_data_rdy_q;
   assign cntlr_present  = cntlr_present_q;
endmodule
